// File: rtl/pcie_os_rx.sv
// Per-lane ordered-set receiver: finds COM, parses SKP/TS1/TS2 straight from
// 10b codes and tracks symbol lock, consecutive TS count and malformed sets.
module pcie_os_rx #(
  parameter logic [9:0] ComNeg   = 10'h17C,
  parameter logic [9:0] ComPos   = 10'h283,
  parameter logic [9:0] SkpNeg   = 10'h0BC,
  parameter logic [9:0] SkpPos   = 10'h343,
  parameter logic [9:0] Ts1Id    = 10'h2AA,
  parameter logic [9:0] Ts2Id    = 10'h2A5,
  parameter int         LockSets = 2,
  parameter int         LossErrs = 4
) (
  input  logic       Clk,
  input  logic       notReset,
  input  logic [9:0] SymIn,
  input  logic       SymValid,
  input  logic       ElecIdle,
  output logic       Locked,
  output logic       OsValid,
  output logic [1:0] OsType,
  output logic [3:0] TsConsec,
  output logic       OsErr,
  output logic [7:0] ErrCnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE, HUNT, ACQ, LOCKED} lock_t;
  typedef enum logic [1:0] {P_WAIT, P_IDX1, P_SKP, P_TS} parse_t;

  lock_t       lstate;
  parse_t      pstate, p_next;
  logic [3:0]  idx, idx_next;
  logic [2:0]  skp_cnt, skp_next;
  logic        ts2, ts2_next, last_ts2;
  logic [3:0]  good_cnt, bad_cnt;
  logic        good, err;
  logic [1:0]  good_type;
  logic        is_com, is_skp;
  logic [9:0]  id_code;

  assign is_com    = (SymIn == ComNeg) || (SymIn == ComPos);
  assign is_skp    = (SymIn == SkpNeg) || (SymIn == SkpPos);
  assign id_code   = ts2 ? Ts2Id : Ts1Id;
  assign dbg_state = lstate;

  // Symbol-level parse of one valid symbol; idx is the position of this symbol after COM.
  always_comb begin
    p_next    = pstate;
    idx_next  = idx;
    skp_next  = skp_cnt;
    ts2_next  = ts2;
    good      = 1'b0;
    good_type = 2'd0;
    err       = 1'b0;
    case (pstate)
      P_WAIT: begin
        if (is_com) p_next = P_IDX1;
        else if (lstate == ACQ) err = 1'b1;
      end
      P_IDX1: begin
        if (is_com) begin
          err = 1'b1;
        end else if (is_skp) begin
          p_next   = P_SKP;
          skp_next = 3'd1;
        end else begin
          p_next   = P_TS;
          idx_next = 4'd2;
        end
      end
      P_SKP: begin
        if (is_skp) begin
          if (skp_cnt == 3'd5) begin
            err    = 1'b1;
            p_next = P_WAIT;
          end else begin
            skp_next = skp_cnt + 3'd1;
          end
        end else begin
          // The terminating symbol is reconsidered as the start of what follows.
          good   = 1'b1;
          p_next = is_com ? P_IDX1 : P_WAIT;
        end
      end
      default: begin
        if (is_com) begin
          err    = 1'b1;
          p_next = P_IDX1;
        end else if (idx == 4'd10) begin
          if (SymIn == Ts1Id) begin
            ts2_next = 1'b0;
            idx_next = 4'd11;
          end else if (SymIn == Ts2Id) begin
            ts2_next = 1'b1;
            idx_next = 4'd11;
          end else begin
            err    = 1'b1;
            p_next = P_WAIT;
          end
        end else if (idx > 4'd10) begin
          if (SymIn != id_code) begin
            err    = 1'b1;
            p_next = P_WAIT;
          end else if (idx == 4'd15) begin
            good      = 1'b1;
            good_type = ts2 ? 2'd2 : 2'd1;
            p_next    = P_WAIT;
          end else begin
            idx_next = idx + 4'd1;
          end
        end else begin
          idx_next = idx + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!notReset) begin
      lstate   <= IDLE;
      pstate   <= P_WAIT;
      idx      <= 4'd0;
      skp_cnt  <= 3'd0;
      ts2      <= 1'b0;
      last_ts2 <= 1'b0;
      good_cnt <= 4'd0;
      bad_cnt  <= 4'd0;
      Locked   <= 1'b0;
      OsValid  <= 1'b0;
      OsType   <= 2'd0;
      TsConsec <= 4'd0;
      OsErr    <= 1'b0;
      ErrCnt   <= 8'd0;
    end else begin
      OsValid <= 1'b0;
      OsErr   <= 1'b0;
      if (ElecIdle) begin
        lstate   <= IDLE;
        Locked   <= 1'b0;
        TsConsec <= 4'd0;
      end else begin
        case (lstate)
          IDLE: lstate <= HUNT;
          HUNT: begin
            if (SymValid && is_com) begin
              lstate   <= ACQ;
              pstate   <= P_IDX1;
              good_cnt <= 4'd0;
            end
          end
          default: begin
            if (SymValid) begin
              pstate  <= p_next;
              idx     <= idx_next;
              skp_cnt <= skp_next;
              ts2     <= ts2_next;
              if (good) begin
                OsValid <= 1'b1;
                OsType  <= good_type;
                if (good_type != 2'd0) begin
                  last_ts2 <= (good_type == 2'd2);
                  if (TsConsec != 4'd0 && ((good_type == 2'd2) == last_ts2))
                    TsConsec <= (TsConsec == 4'd15) ? 4'd15 : TsConsec + 4'd1;
                  else
                    TsConsec <= 4'd1;
                end
                bad_cnt <= 4'd0;
                if (lstate == ACQ) begin
                  if (good_cnt == 4'(LockSets - 1)) begin
                    lstate <= LOCKED;
                    Locked <= 1'b1;
                  end else begin
                    good_cnt <= good_cnt + 4'd1;
                  end
                end
              end
              if (err) begin
                OsErr    <= 1'b1;
                TsConsec <= 4'd0;
                if (ErrCnt != 8'hFF) ErrCnt <= ErrCnt + 8'd1;
                if (lstate == ACQ) begin
                  good_cnt <= 4'd0;
                  if (p_next != P_IDX1) lstate <= HUNT;
                end else if (bad_cnt == 4'(LossErrs - 1)) begin
                  // A COM that caused the final error already gives set alignment.
                  lstate   <= (p_next == P_IDX1) ? ACQ : HUNT;
                  Locked   <= 1'b0;
                  good_cnt <= 4'd0;
                  bad_cnt  <= 4'd0;
                end else begin
                  bad_cnt <= bad_cnt + 4'd1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcie_os_rx.sv
// Bench for pcie_os_rx: directed ordered-set scenarios with literal checks, then
// randomized set streams compared every cycle against a set-buffer reference model.
module tb_pcie_os_rx;

  localparam logic [9:0] COM_N = 10'h17C, COM_P = 10'h283;
  localparam logic [9:0] SKP_N = 10'h0BC, SKP_P = 10'h343;
  localparam logic [9:0] TS1   = 10'h2AA, TS2   = 10'h2A5;
  localparam int LOCK_SETS = 2, LOSS_ERRS = 4;

  logic       clk = 1'b0;
  logic       rst_n, sym_valid, elec_idle;
  logic [9:0] sym_in;
  logic       locked, os_valid, os_err;
  logic [1:0] os_type, dbg_state;
  logic [3:0] ts_consec;
  logic [7:0] err_cnt;

  int n_chk = 0, n_err = 0, cnt_v = 0;
  bit gap_en = 0;

  pcie_os_rx dut (
    .Clk(clk), .notReset(rst_n), .SymIn(sym_in), .SymValid(sym_valid),
    .ElecIdle(elec_idle), .Locked(locked), .OsValid(os_valid), .OsType(os_type),
    .TsConsec(ts_consec), .OsErr(os_err), .ErrCnt(err_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: works on the buffered set contents ----------------
  int         m_mode;   // 0 idle, 1 hunt, 2 acquiring, 3 locked
  bit         m_inset;
  logic [9:0] m_buf[$];
  int         m_good, m_bad, m_last;
  logic       e_locked = 0, e_valid = 0, e_err = 0;
  logic [1:0] e_type = 0;
  int         e_consec = 0, e_errcnt = 0;

  function automatic bit f_com(input logic [9:0] s);
    return s == COM_N || s == COM_P;
  endfunction
  function automatic bit f_skp(input logic [9:0] s);
    return s == SKP_N || s == SKP_P;
  endfunction

  task automatic m_error(input bit with_com);
    e_err = 1;
    if (e_errcnt < 255) e_errcnt++;
    e_consec = 0;
    m_inset = with_com;
    m_buf.delete();
    if (m_mode == 2) begin
      m_good = 0;
      if (!with_com) m_mode = 1;
    end else begin
      m_bad++;
      if (m_bad == LOSS_ERRS) begin
        e_locked = 0; m_bad = 0; m_good = 0;
        m_mode = with_com ? 2 : 1;
      end
    end
  endtask

  task automatic m_good_set(input int t);
    e_valid = 1;
    e_type = 2'(t);
    if (t != 0) begin
      e_consec = (e_consec != 0 && t == m_last) ? ((e_consec == 15) ? 15 : e_consec + 1) : 1;
      m_last = t;
    end
    m_bad = 0;
    if (m_mode == 2) begin
      m_good++;
      if (m_good == LOCK_SETS) begin
        m_mode = 3;
        e_locked = 1;
      end
    end
  endtask

  task automatic m_step(input logic r, input logic idle, input logic v, input logic [9:0] s);
    e_valid = 0;
    e_err = 0;
    if (!r) begin
      e_locked = 0; e_type = 0; e_consec = 0; e_errcnt = 0;
      m_mode = 0; m_inset = 0; m_buf.delete(); m_good = 0; m_bad = 0; m_last = 0;
      return;
    end
    if (idle) begin
      m_mode = 0; e_locked = 0; e_consec = 0;
      return;
    end
    if (m_mode == 0) begin m_mode = 1; return; end
    if (!v) return;
    if (m_mode == 1) begin
      if (f_com(s)) begin m_mode = 2; m_good = 0; m_inset = 1; m_buf.delete(); end
      return;
    end
    if (!m_inset) begin
      if (f_com(s)) begin m_inset = 1; m_buf.delete(); end
      else if (m_mode == 2) m_error(0);
      return;
    end
    if (m_buf.size() > 0 && f_skp(m_buf[0])) begin
      if (f_skp(s)) begin
        if (m_buf.size() == 5) m_error(0);
        else m_buf.push_back(s);
      end else begin
        m_good_set(0);
        m_inset = f_com(s);
        m_buf.delete();
      end
      return;
    end
    if (f_com(s)) begin m_error(1); return; end
    m_buf.push_back(s);
    if (m_buf.size() >= 10) begin
      if (m_buf[9] != TS1 && m_buf[9] != TS2) m_error(0);
      else if (s != m_buf[9]) m_error(0);
      else if (m_buf.size() == 15) begin
        m_good_set(m_buf[9] == TS1 ? 1 : 2);
        m_inset = 0;
        m_buf.delete();
      end
    end
  endtask

  // Single compare process: model advances on the edge, DUT outputs checked just after it.
  always @(posedge clk) begin
    m_step(rst_n, elec_idle, sym_valid, sym_in);
    #1;
    chk("locked", locked, e_locked);
    chk("os_valid", os_valid, e_valid);
    if (e_valid) chk("os_type", os_type, e_type);
    chk("ts_consec", ts_consec, e_consec);
    chk("os_err", os_err, e_err);
    chk("err_cnt", err_cnt, e_errcnt);
    if (os_valid === 1'b1) cnt_v++;
  end

  // ---------------- drivers ----------------
  function automatic logic [9:0] com_code();
    return ($urandom_range(0, 1) == 1) ? COM_P : COM_N;
  endfunction

  function automatic logic [9:0] rand_data(input logic [9:0] ex);
    logic [9:0] d;
    do d = 10'($urandom_range(0, 1023));
    while (f_com(d) || f_skp(d) || d == ex);
    return d;
  endfunction

  task automatic send_sym(input logic [9:0] s);
    if (gap_en && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        sym_valid = 0;
        sym_in = 10'($urandom_range(0, 1023));
      end
    @(negedge clk);
    sym_valid = 1;
    sym_in = s;
  endtask

  task automatic settle();
    @(negedge clk);
    sym_valid = 0;
  endtask

  // Indices 1..15 of a TS; bad_pos (10..15) replaces that ID symbol with a wrong one.
  task automatic send_ts_body(input logic [9:0] id, input int bad_pos);
    for (int i = 1; i <= 9; i++) send_sym(rand_data(10'h000));
    for (int i = 10; i <= 15; i++) begin
      if (i == bad_pos) send_sym(rand_data(id));
      else send_sym(id);
    end
  endtask

  task automatic send_ts(input logic [9:0] id, input int bad_pos);
    send_sym(com_code());
    send_ts_body(id, bad_pos);
  endtask

  task automatic send_skp(input int n);
    send_sym(com_code());
    repeat (n) send_sym(($urandom_range(0, 1) == 1) ? SKP_P : SKP_N);
  endtask

  task automatic send_partial(input int n_data);
    send_sym(com_code());
    repeat (n_data) send_sym(rand_data(10'h000));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, r;
    rst_n = 0; elec_idle = 1; sym_valid = 0; sym_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_consec", ts_consec, 0);
    rst_n = 1;

    // Lock on TS1
    elec_idle = 0;
    repeat (3) send_sym(rand_data(10'h000));
    v0 = cnt_v;
    send_ts(TS1, 0);
    send_ts(TS1, 0);
    settle();
    chk("t1_locked_after_2", locked, 1);
    send_ts(TS1, 0);
    settle();
    chk("t1_valid_count", cnt_v - v0, 3);
    chk("t1_type", os_type, 1);
    chk("t1_consec", ts_consec, 3);

    // SKP lengths
    send_skp(3);
    send_sym(com_code());
    settle();
    chk("t2_skp_type", os_type, 0);
    chk("t2_consec_kept", ts_consec, 3);
    send_ts_body(TS1, 0);
    settle();
    chk("t2_consec_4", ts_consec, 4);
    send_skp(6);
    settle();
    chk("t2_skp6_errcnt", err_cnt, 1);
    chk("t2_skp6_consec", ts_consec, 0);
    chk("t2_still_locked", locked, 1);

    // TS type change and saturation
    repeat (8) send_ts(TS1, 0);
    settle();
    chk("t3_consec_8", ts_consec, 8);
    send_ts(TS2, 0);
    settle();
    chk("t3_consec_1", ts_consec, 1);
    chk("t3_type_ts2", os_type, 2);
    repeat (20) send_ts(TS2, 0);
    settle();
    chk("t3_consec_sat", ts_consec, 15);

    // Lock loss
    repeat (3) send_ts(TS1, 12);
    settle();
    chk("t4_locked_after_3", locked, 1);
    send_ts(TS1, 12);
    settle();
    chk("t4_unlocked", locked, 0);
    chk("t4_errcnt", err_cnt, 5);
    send_ts(TS1, 0);
    settle();
    chk("t4_acq_one", locked, 0);
    chk("t4_acq_consec", ts_consec, 1);
    send_ts(TS1, 0);
    settle();
    chk("t4_relocked", locked, 1);

    // Early COM at index 7
    send_partial(6);
    send_ts(TS2, 0);
    settle();
    chk("t5_errcnt", err_cnt, 6);
    chk("t5_consec", ts_consec, 1);
    chk("t5_type", os_type, 2);

    // Idle with final symbol, then relock with symbol gaps
    v0 = cnt_v;
    send_partial(9);
    repeat (5) send_sym(TS1);
    @(negedge clk);
    elec_idle = 1; sym_valid = 1; sym_in = TS1;
    @(negedge clk);
    chk("t6_idle_unlock", locked, 0);
    chk("t6_idle_no_valid", cnt_v - v0, 0);
    elec_idle = 0;
    gap_en = 1;
    repeat (2) send_sym(rand_data(10'h000));
    send_ts(TS1, 0);
    send_ts(TS1, 0);
    settle();
    chk("t6_gap_locked", locked, 1);
    chk("t6_gap_consec", ts_consec, 2);
    chk("t6_gap_count", cnt_v - v0, 2);
    send_partial(5);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_type", os_type, 0);
    chk("t6_rst_consec", ts_consec, 0);
    chk("t6_rst_errcnt", err_cnt, 0);

    // Randomized stream
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35) send_ts(($urandom_range(0, 1) == 1) ? TS2 : TS1, 0);
      else if (r < 55) send_skp($urandom_range(1, 6));
      else if (r < 65) send_ts(($urandom_range(0, 1) == 1) ? TS2 : TS1, $urandom_range(10, 15));
      else if (r < 72) send_partial($urandom_range(1, 14));
      else if (r < 85) repeat ($urandom_range(1, 3)) send_sym(rand_data(10'h000));
      else if (r < 92) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          elec_idle = 1;
          sym_valid = 1'($urandom_range(0, 1));
          sym_in = com_code();
        end
        elec_idle = 0;
        repeat (2) send_sym(rand_data(10'h000));
      end else if (r < 94) begin
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end else send_ts(TS1, 0);
    end
    settle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pcie_os_rx.md
# pcie_os_rx

Per-lane ordered-set receiver that sits on the DUT side of a `PcieVhost` link. It consumes the 10-bit encoded symbol stream the host model drives on one `LinkOutN`. It acquires symbol lock on COM, parses SKP, TS1 and TS2 ordered sets directly from 10b codes, without a full 8b/10b decode. It reports parsed sets, a consecutive-TS count and error events to an LTSSM-style consumer. One instance is used per lane.

## Interface

Parameters:
- `ComNeg`, 10'h17C: COM (K28.5) code, RD-
- `ComPos`, 10'h283: COM (K28.5) code, RD+
- `SkpNeg`, 10'h0BC: SKP (K28.0) code, RD-
- `SkpPos`, 10'h343: SKP (K28.0) code, RD+
- `Ts1Id`, 10'h2AA: TS1 identifier (D10.2), disparity-neutral
- `Ts2Id`, 10'h2A5: TS2 identifier (D5.2), disparity-neutral
- `LockSets`, 2: consecutive good ordered sets required to assert lock
- `LossErrs`, 4: consecutive malformed sets that drop lock

Ports:
- `Clk`, in, 1: sole clock, rising edge
- `notReset`, in, 1: synchronous, active-low reset
- `SymIn`, in, 10: received 10b symbol
- `SymValid`, in, 1: `SymIn` valid this cycle; when low, all state holds
- `ElecIdle`, in, 1: lane in electrical idle
- `Locked`, out, 1: symbol lock achieved
- `OsValid`, out, 1: one-cycle pulse, a good ordered set has completed
- `OsType`, out, 2: type of the completed set; 0 = SKP, 1 = TS1, 2 = TS2; held until the next `OsValid`
- `TsConsec`, out, 4: consecutive same-type TS count, saturates at 15
- `OsErr`, out, 1: one-cycle pulse, a malformed set was detected
- `ErrCnt`, out, 8: total malformed sets; saturates at 255; cleared only by reset

## Operation

Definitions:
- COM is `ComNeg` or `ComPos`.
- SKP is `SkpNeg` or `SkpPos`.
- Symbol processing occurs only on cycles with `SymValid`=1.

Lock FSM:
- **IDLE**
  - Entered from reset, and from any state when `ElecIdle`=1.
  - `ElecIdle`=0 -> HUNT.
- **HUNT**
  - Non-COM symbols are discarded.
  - COM -> ACQ; the parser starts at index 1.
- **ACQ**
  - The parser runs.
  - The good-set counter increments on each good set and clears on any error.
  - Reaching `LockSets` -> LOCKED.
  - An error returns to HUNT.
- **LOCKED**
  - `Locked`=1 and the parser runs.
  - The consecutive-error counter clears on each good set.
  - `LossErrs` consecutive errors -> HUNT, with `Locked`=0.

Parser (active in ACQ and LOCKED; the index is the symbol position after COM):
- **Index 1, SKP:** SKP set with skpcount=1. Each further SKP increments skpcount.
  - A non-SKP symbol after 1–5 SKPs completes a good SKP set. That symbol is then processed as a fresh symbol: COM starts a new set, anything else goes to wait-COM.
  - A 6th SKP is an error.
- **Index 1, other non-COM:** TS candidate; indices 1–9 are unchecked.
  - Index 10 latches the type: `Ts1Id` -> TS1, `Ts2Id` -> TS2, anything else -> error.
  - Indices 11–15 must equal the latched ID, else error.
  - Index 15 matching completes a good TS.
- **COM at any index 1–15 of a TS:** error; the COM starts a new set at index 1.
- **After an error (other than the COM case):** wait-COM, discarding symbols until COM.
- **In LOCKED, non-COM symbols while in wait-COM:** ignored, not errors.

Consecutive-TS count (`TsConsec`):
- A good TS of the same type as the previous TS increments it, saturating at 15.
- A TS of a different type sets it to 1.
- SKP sets leave it unchanged.
- Any error, IDLE or HUNT clears it to 0.

## Timing

- All outputs are registered. The event on the sampling edge of a symbol is visible in the following cycle.
- `OsValid`/`OsType`:
  - For a TS, asserted the cycle after the index-15 symbol is sampled.
  - For a SKP, asserted the cycle after the terminating non-SKP symbol is sampled.
- `OsErr` is asserted the cycle after the offending symbol. `ErrCnt` updates on the same edge.
- `Locked` rises on the same edge as the `OsValid` of the `LockSets`-th good set. It falls on the edge of the `LossErrs`-th error, or one edge after `ElecIdle` is sampled high.
- Simultaneous `ElecIdle`=1 with a final symbol: idle wins; no `OsValid` is produced.
- When `SymValid`=0, pulses do not fire and the indices hold.
- Reset: `Locked`, `OsValid`, `OsType`, `TsConsec`, `OsErr` and `ErrCnt` are all 0 after the first edge with `notReset`=0, including when reset is asserted mid-set. The FSM enters IDLE.

## Test plan

1. **Lock on TS1:** `ElecIdle`=0, then 3 TS1 sets (COM, 9 × D0.0, 6 × 2AA) -> `OsValid`/`OsType`=1 ×3; `Locked`=1 after the 2nd set; `TsConsec`=1,2,3.
2. **SKP lengths:** locked; send COM + 3 SKP + COM -> `OsValid`, `OsType`=0, `TsConsec` unchanged. Send COM + 6 SKP -> `OsErr`, `ErrCnt`+1.
3. **TS type change:** 8 TS1 then 1 TS2 -> `TsConsec` reaches 8, then 1 with `OsType`=2. Then 20 TS2 -> saturates at 15.
4. **Lock loss:** locked; 4 sets with a bad ID at index 12 -> 4 `OsErr` pulses; `Locked` falls on the 4th; the next COM re-enters ACQ.
5. **Early COM:** COM at index 7 of a TS -> `OsErr`; the following 15 TS2 symbols complete a good TS2.
6. **Idle and reset:** `ElecIdle`=1 mid-set -> `Locked`=0 next cycle, no `OsValid`. `notReset`=0 for one cycle mid-set -> all outputs 0, `ErrCnt`=0. `SymValid` gaps inside a set -> identical result to the gap-free stream.
